// File: rtl/led_sequencer_if.sv
// led_sequencer_if: control and LED bundle between the board top and the
// LED pattern sequencer.
//   EN      - prescaler enable (1 = pattern runs, 0 = frozen)
//   MODE    - pattern select: 00 chase, 01 bounce, 10 blink all, 11 off
//   BRIGHT  - PWM duty for lit red LEDs, 0 = dark
//   RLED1-4 - red LEDs, active-high
//   GLED5   - green pattern-cycle marker
//   STEP    - one-cycle pulse per pattern step
// master: board/controller side; slave: the sequencer.
interface led_sequencer_if #(
  parameter int PWM_BITS = 8
);
  logic                EN;
  logic [1:0]          MODE;
  logic [PWM_BITS-1:0] BRIGHT;
  logic                RLED1;
  logic                RLED2;
  logic                RLED3;
  logic                RLED4;
  logic                GLED5;
  logic                STEP;

  modport master (
    output EN, MODE, BRIGHT,
    input  RLED1, RLED2, RLED3, RLED4, GLED5, STEP
  );

  modport slave (
    input  EN, MODE, BRIGHT,
    output RLED1, RLED2, RLED3, RLED4, GLED5, STEP
  );
endinterface

// File: rtl/led_sequencer.sv
// led_sequencer: divides CLK_IN into a slow step tick and advances a
// four-LED red pattern (chase, bounce, blink) on each tick. Lit LEDs are
// dimmed by a free-running PWM; the green LED toggles once per completed
// pattern cycle.
//   CLK_IN - system clock, all state on its rising edge
//   RST_IN - asynchronous, active-high reset
//   bus    - led_sequencer_if.slave (EN, MODE, BRIGHT in; RLED1-4, GLED5,
//            STEP out, all outputs registered)
// Parameters: STEP_DIV (clock cycles per step, >= 2), PWM_BITS (PWM and
// BRIGHT width).
module led_sequencer #(
  parameter int STEP_DIV = 1200000,
  parameter int PWM_BITS = 8
) (
  input  logic            CLK_IN,
  input  logic            RST_IN,
  led_sequencer_if.slave  bus
);

  localparam int                PRE_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    MODE_CHASE  = 2'b00,
    MODE_BOUNCE = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_OFF    = 2'b11
  } mode_t;

  logic [PRE_W-1:0]    prescaler;
  logic [PWM_BITS-1:0] pwm_cnt;

  logic [1:0] pos;
  logic       dir;        // 0 = up, 1 = down
  logic       phase;
  mode_t      cur_mode;
  logic       green;

  logic       tick_p0;
  logic       pwm_on_p0;
  logic [3:0] sel_p0;

  logic [3:0] rled_p1;
  logic       gled_p1;
  logic       step_p1;

  // ---- stage p0: step tick, PWM compare and LED selection from current state
  // EN gates the tick directly, so dropping EN on the terminal count cycle
  // suppresses that tick while the prescaler holds and retries it later.
  assign tick_p0   = bus.EN && (prescaler == PRE_LAST);
  assign pwm_on_p0 = (pwm_cnt < bus.BRIGHT);

  always_comb begin
    sel_p0 = 4'b0000;
    case (cur_mode)
      MODE_CHASE,
      MODE_BOUNCE: sel_p0 = 4'b0001 << pos;
      MODE_BLINK:  sel_p0 = phase ? 4'b1111 : 4'b0000;
      default:     sel_p0 = 4'b0000;
    endcase
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (bus.EN) begin
        prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + PRE_W'(1);
      end
    end
  end

  // Pattern FSM. A tick that sees a new MODE only re-enters that pattern at
  // its start; it does not also advance.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      pos      <= 2'd0;
      dir      <= 1'b0;
      phase    <= 1'b0;
      cur_mode <= MODE_CHASE;
      green    <= 1'b0;
    end else if (tick_p0) begin
      if (mode_t'(bus.MODE) != cur_mode) begin
        cur_mode <= mode_t'(bus.MODE);
        pos      <= 2'd0;
        dir      <= 1'b0;
        phase    <= 1'b0;
      end else begin
        case (cur_mode)
          MODE_CHASE: begin
            pos <= pos + 2'd1;
            if (pos == 2'd3) begin
              green <= ~green;
            end
          end
          MODE_BOUNCE: begin
            // Endpoints reverse immediately so each is shown once per sweep.
            if (!dir) begin
              if (pos == 2'd3) begin
                pos <= 2'd2;
                dir <= 1'b1;
              end else begin
                pos <= pos + 2'd1;
              end
            end else begin
              if (pos == 2'd0) begin
                pos <= 2'd1;
                dir <= 1'b0;
              end else begin
                pos <= pos - 2'd1;
                if (pos == 2'd1) begin
                  green <= ~green;
                end
              end
            end
          end
          MODE_BLINK: phase <= ~phase;
          default: ;
        endcase
      end
    end
  end

  // ---- stage p1: registered LED and step outputs
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      rled_p1 <= 4'b0000;
      gled_p1 <= 1'b0;
      step_p1 <= 1'b0;
    end else begin
      rled_p1 <= sel_p0 & {4{pwm_on_p0}};
      gled_p1 <= green;
      step_p1 <= tick_p0;
    end
  end

  assign bus.RLED1 = rled_p1[0];
  assign bus.RLED2 = rled_p1[1];
  assign bus.RLED3 = rled_p1[2];
  assign bus.RLED4 = rled_p1[3];
  assign bus.GLED5 = gled_p1;
  assign bus.STEP  = step_p1;

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: checks led_sequencer (STEP_DIV=4, PWM_BITS=4) against a
// step-index model of the patterns on every cycle, plus directed scenarios
// with hand-written LED sequences.
module tb_led_sequencer;
  localparam int STEP_DIV = 4;
  localparam int PWM_BITS = 4;
  localparam int PWM_LEN  = 1 << PWM_BITS;

  logic CLK_IN = 1'b0;
  logic RST_IN = 1'b1;

  led_sequencer_if #(.PWM_BITS(PWM_BITS)) bus ();

  led_sequencer #(.STEP_DIV(STEP_DIV), .PWM_BITS(PWM_BITS)) dut (
    .CLK_IN (CLK_IN),
    .RST_IN (RST_IN),
    .bus    (bus)
  );

  initial forever #5 CLK_IN = ~CLK_IN;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The pattern is described by k = number of advances since the current
  // mode was entered; LED position comes from a per-mode table.
  int          bounce_tbl [6] = '{0, 1, 2, 3, 2, 1};
  int          m_pre   = 0;
  int          m_pwm   = 0;
  int          m_k     = 0;
  logic [1:0]  m_mode  = 2'b00;
  bit          m_green = 1'b0;
  logic [5:0]  exp_out = 6'd0;   // {STEP, GLED5, RLED4..RLED1}

  function automatic logic [3:0] model_sel(input logic [1:0] mode, input int k);
    case (mode)
      2'b00:   return 4'b0001 << (k % 4);
      2'b01:   return 4'b0001 << bounce_tbl[k % 6];
      2'b10:   return (k % 2 == 1) ? 4'b1111 : 4'b0000;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_reset();
    m_pre = 0; m_pwm = 0; m_k = 0; m_mode = 2'b00; m_green = 1'b0;
    exp_out = 6'd0;
  endtask

  task automatic model_step();
    bit         tick;
    logic [3:0] r;
    tick = bus.EN && (m_pre == STEP_DIV - 1);
    r = model_sel(m_mode, m_k) & ((m_pwm < int'(bus.BRIGHT)) ? 4'hF : 4'h0);
    exp_out = {tick, m_green, r};
    m_pwm = (m_pwm + 1) % PWM_LEN;
    if (bus.EN) m_pre = (m_pre + 1) % STEP_DIV;
    if (tick) begin
      if (bus.MODE != m_mode) begin
        m_mode = bus.MODE;
        m_k    = 0;
      end else if (m_mode != 2'b11) begin
        m_k = m_k + 1;
        if ((m_mode == 2'b00 && m_k % 4 == 0) || (m_mode == 2'b01 && m_k % 6 == 0))
          m_green = ~m_green;
      end
    end
  endtask

  initial forever begin
    @(posedge CLK_IN or posedge RST_IN);
    if (RST_IN) model_reset();
    else        model_step();
  end

  function automatic logic [5:0] dut_out();
    return {bus.STEP, bus.GLED5, bus.RLED4, bus.RLED3, bus.RLED2, bus.RLED1};
  endfunction

  function automatic logic [3:0] leds();
    return {bus.RLED4, bus.RLED3, bus.RLED2, bus.RLED1};
  endfunction

  // Compare process: every cycle, away from the active edge.
  initial forever begin
    @(negedge CLK_IN);
    check("model_compare", int'(dut_out()), int'(exp_out));
  end

  // ---------------- directed helpers ----------------
  logic [3:0] q_sel [$];
  bit         q_grn [$];

  task automatic do_reset();
    @(negedge CLK_IN);
    RST_IN = 1'b1;
    repeat (2) @(negedge CLK_IN);
    RST_IN = 1'b0;
  endtask

  task automatic wait_step(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge CLK_IN);
      if (bus.STEP) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic sample_sel(output logic [3:0] lit);
    lit = 4'b0000;
    repeat (3) begin
      @(negedge CLK_IN);
      lit |= leds();
    end
  endtask

  // Walks the queued expected selections: for each step, checks the gap to
  // STEP, the lit LEDs after it and GLED5.
  task automatic run_seq(input string name, input int first_gap);
    int         n;
    logic [3:0] lit;
    for (int s = 0; s < q_sel.size(); s++) begin
      wait_step(20, n);
      check({name, "_step_gap"}, n, (s == 0) ? first_gap : 1);
      sample_sel(lit);
      check({name, "_leds"}, int'(lit), int'(q_sel[s]));
      check({name, "_gled"}, int'(bus.GLED5), int'(q_grn[s]));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         n;
    int         c1;
    int         steps;
    logic [3:0] other;
    logic [3:0] lit;

    bus.EN = 1'b1; bus.MODE = 2'b00; bus.BRIGHT = 4'd15;
    repeat (2) @(negedge CLK_IN);
    check("reset_outputs", int'(dut_out()), 0);

    // Chase from reset: lit index 1,2,3,0,1; green toggles on 3->0.
    do_reset();
    q_sel = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    q_grn = '{0, 0, 0, 1, 1};
    run_seq("chase", STEP_DIV);

    // Bounce from reset: first tick is the mode entry, then 1,2,3,2,1,0,1.
    bus.MODE = 2'b01;
    do_reset();
    q_sel = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    q_grn = '{0, 0, 0, 0, 0, 0, 1, 1};
    run_seq("bounce", STEP_DIV);

    // PWM duty at pos 0 with the pattern frozen.
    bus.EN = 1'b0; bus.MODE = 2'b00; bus.BRIGHT = 4'd4;
    do_reset();
    @(negedge CLK_IN);
    c1 = 0; other = 4'b0000; steps = 0;
    repeat (PWM_LEN) begin
      @(negedge CLK_IN);
      c1 += int'(bus.RLED1);
      other |= leds() & 4'b1110;
      steps += int'(bus.STEP);
    end
    check("pwm4_on_cycles", c1, 4);
    check("pwm4_other_leds", int'(other), 0);
    check("pwm4_no_step", steps, 0);
    bus.BRIGHT = 4'd0;
    repeat (2) @(negedge CLK_IN);
    c1 = 0;
    repeat (PWM_LEN) begin
      @(negedge CLK_IN);
      c1 += int'(bus.RLED1) + int'(bus.RLED2) + int'(bus.RLED3) + int'(bus.RLED4);
    end
    check("pwm0_dark", c1, 0);

    // EN pause after 2 prescaler counts, then resume.
    bus.EN = 1'b1; bus.BRIGHT = 4'd15;
    do_reset();
    repeat (2) @(negedge CLK_IN);
    bus.EN = 1'b0;
    steps = 0; lit = 4'b0000;
    repeat (10) begin
      @(negedge CLK_IN);
      steps += int'(bus.STEP);
      lit |= leds();
    end
    check("pause_no_step", steps, 0);
    check("pause_leds_frozen", int'(lit), 1);
    bus.EN = 1'b1;
    wait_step(20, n);
    check("resume_gap", n, 2);
    // Drop EN on the would-be tick cycle: that tick waits for EN.
    repeat (3) @(negedge CLK_IN);
    bus.EN = 1'b0;
    steps = 0;
    repeat (3) begin
      @(negedge CLK_IN);
      steps += int'(bus.STEP);
    end
    check("suppressed_tick", steps, 0);
    bus.EN = 1'b1;
    wait_step(20, n);
    check("suppressed_resume_gap", n, 1);

    // Mode change chase -> blink at pos 2, then -> off.
    bus.MODE = 2'b00;
    do_reset();
    q_sel = '{4'b0010, 4'b0100};
    q_grn = '{0, 0};
    run_seq("pre_blink", STEP_DIV);
    bus.MODE = 2'b10;
    q_sel = '{4'b0000, 4'b1111, 4'b0000, 4'b1111};
    q_grn = '{0, 0, 0, 0};
    run_seq("blink", 1);
    bus.MODE = 2'b11;
    q_sel = '{4'b0000, 4'b0000};
    q_grn = '{0, 0};
    run_seq("off", 1);

    // Asynchronous reset between edges, then the chase restarts cleanly.
    bus.MODE = 2'b00;
    do_reset();
    q_sel = '{4'b0010, 4'b0100};
    q_grn = '{0, 0};
    run_seq("pre_async", STEP_DIV);
    @(negedge CLK_IN);
    #2 RST_IN = 1'b1;
    #1 check("async_reset_outputs", int'(dut_out()), 0);
    @(negedge CLK_IN);
    RST_IN = 1'b0;
    q_sel = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    q_grn = '{0, 0, 0, 1, 1};
    run_seq("restart", STEP_DIV);

    // Randomized traffic, checked by the per-cycle model compare.
    bus.MODE = 2'($urandom_range(0, 3));
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      @(negedge CLK_IN);
      bus.EN = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 24) == 0) bus.MODE   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) bus.BRIGHT = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) begin
        #2 RST_IN = 1'b1;
        @(negedge CLK_IN);
        RST_IN = 1'b0;
      end
    end

    @(negedge CLK_IN);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
